qpu_exu_trigger_ctrl: RTL and testbench

//  Sequences the exu time queue: owns the experiment timestamp counter and drives the queue's

---
 rtl/qpu_exu_trigger_ctrl_pkg.sv | 19 +
 rtl/qpu_exu_trigger_ctrl_if.sv | 26 ++
 rtl/qpu_exu_trig_wdog.sv | 34 +++
 rtl/qpu_exu_trigger_ctrl.sv | 99 +++++++++
 tb/tb_qpu_exu_trigger_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/qpu_exu_trigger_ctrl_pkg.sv
// Shared definitions for the exu trigger controller: state encodings, error-bit indices and
// the default timestamp width.
package qpu_exu_trigger_ctrl_pkg;

    localparam int unsigned TimeWDefault = 16;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StStall = 2'd2;
    localparam logic [1:0] StErr   = 2'd3;

    localparam int unsigned ErrOvf = 0;
    localparam int unsigned ErrTmo = 1;

    function automatic logic state_busy(input logic [1:0] st);
        return (st == StRun) || (st == StStall);
    endfunction

endpackage

// File: rtl/qpu_exu_trigger_ctrl_if.sv
// Host control and time-queue signals of the trigger controller, bundled as one interface.
interface qpu_exu_trigger_ctrl_if
    import qpu_exu_trigger_ctrl_pkg::*;
#(
    parameter int unsigned TIME_W = TimeWDefault
);
    logic              i_start;
    logic              i_stop;
    logic              i_clr_err;
    logic              i_clk_ena;
    logic              o_trigger;
    logic [TIME_W-1:0] o_clk;
    logic              o_busy;
    logic              o_stall;
    logic [1:0]        o_err;

    modport master (
        output i_start, i_stop, i_clr_err, i_clk_ena,
        input  o_trigger, o_clk, o_busy, o_stall, o_err
    );

    modport slave (
        input  i_start, i_stop, i_clr_err, i_clk_ena,
        output o_trigger, o_clk, o_busy, o_stall, o_err
    );
endinterface

// File: rtl/qpu_exu_trig_wdog.sv
// Stall watchdog: counts consecutive enabled cycles and pulses timeout on the WDOG_LIMIT-th one.
module qpu_exu_trig_wdog #(
    parameter int unsigned WDOG_W     = 12,
    parameter int unsigned WDOG_LIMIT = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic timeout
);
    localparam logic [WDOG_W-1:0] LastCnt = WDOG_W'(WDOG_LIMIT - 1);

    logic [WDOG_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = en && !clr && (cnt_q == LastCnt);
endmodule

// File: rtl/qpu_exu_trigger_ctrl.sv
// Exu time-queue sequencer: owns the experiment timestamp and trigger. Define QPU_TRIG_WDOG_EN to
// add the stall watchdog (timeout error); otherwise STALL may last indefinitely.
module qpu_exu_trigger_ctrl
    import qpu_exu_trigger_ctrl_pkg::*;
#(
    parameter int unsigned TIME_W     = TimeWDefault,
    parameter int unsigned WDOG_W     = 12,
    parameter int unsigned WDOG_LIMIT = 4095
) (
    input logic                    clk,
    input logic                    rst,
    qpu_exu_trigger_ctrl_if.slave  bus
);
    localparam logic [TIME_W-1:0] TimeMax = '1;

    if (WDOG_LIMIT < 1 || WDOG_LIMIT > (2 ** WDOG_W) - 1) begin : g_bad_wdog_cfg
        $error("WDOG_LIMIT must lie in 1 .. 2**WDOG_W-1");
    end

    logic [1:0]        state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [1:0]        err_q, err_d;
    logic              busy_q, stall_q;
    logic              ovf, timeout;

`ifdef QPU_TRIG_WDOG_EN
    qpu_exu_trig_wdog #(
        .WDOG_W     (WDOG_W),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == StStall),
        .clr     (state_q != StStall),
        .timeout (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // Priority: stop > error > clk_ena > start.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        err_d   = err_q;
        ovf     = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.i_start && !bus.i_stop) begin
                    state_d = StRun;
                    time_d  = '0;
                end
            end
            StRun, StStall: begin
                ovf = bus.i_clk_ena && (time_q == TimeMax);
                if (bus.i_stop) begin
                    state_d = StIdle;
                end else if (ovf || timeout) begin
                    state_d        = StErr;
                    err_d[ErrOvf]  = ovf;
                    err_d[ErrTmo]  = timeout;
                end else if (bus.i_clk_ena) begin
                    state_d = StRun;
                    time_d  = time_q + 1'b1;
                end else begin
                    state_d = StStall;
                end
            end
            default: begin
                if (bus.i_clr_err) begin
                    state_d = StIdle;
                    err_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            time_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            err_q   <= err_d;
            busy_q  <= state_busy(state_d);
            stall_q <= (state_d == StStall);
        end
    end

    assign bus.o_trigger = busy_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_stall   = stall_q;
    assign bus.o_clk     = time_q;
    assign bus.o_err     = err_q;
endmodule

// File: tb/tb_qpu_exu_trigger_ctrl.sv
// Randomised and directed bench for qpu_exu_trigger_ctrl against a cycle-level behavioural model.
module tb_qpu_exu_trigger_ctrl;
    localparam int TW         = 4;
    localparam int WLIMIT     = 8;
    localparam int TMAX       = (1 << TW) - 1;
`ifdef QPU_TRIG_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qpu_exu_trigger_ctrl_if #(.TIME_W(TW)) bus ();

    qpu_exu_trigger_ctrl #(
        .TIME_W     (TW),
        .WDOG_W     (4),
        .WDOG_LIMIT (WLIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: experiment mode, timestamp, sticky errors and length of the current stall.
    typedef enum int {MIdle, MRun, MStall, MErr} mode_t;
    mode_t m_mode;
    int    m_time;
    int    m_stall_len;
    bit    m_ovf, m_tmo;

    task automatic model_reset();
        m_mode = MIdle; m_time = 0; m_stall_len = 0; m_ovf = 0; m_tmo = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c, input bit e);
        mode_t old = m_mode;
        bit ovf, tmo;
        if (m_mode == MIdle) begin
            if (s && !p) begin m_mode = MRun; m_time = 0; end
        end else if (m_mode == MErr) begin
            if (c) begin m_mode = MIdle; m_ovf = 0; m_tmo = 0; end
        end else begin
            ovf = e && (m_time == TMAX);
            tmo = WDOG_ON && (m_mode == MStall) && (m_stall_len + 1 == WLIMIT);
            if (p) m_mode = MIdle;
            else if (ovf || tmo) begin m_mode = MErr; m_ovf = ovf; m_tmo = tmo; end
            else if (e) begin m_mode = MRun; m_time = m_time + 1; end
            else m_mode = MStall;
        end
        m_stall_len = (old == MStall) ? m_stall_len + 1 : 0;
    endtask

    function automatic logic [TW+4:0] exp_vec();
        bit busy = (m_mode == MRun) || (m_mode == MStall);
        logic [TW-1:0] t = TW'(m_time);
        return {busy, busy, m_mode == MStall, m_tmo, m_ovf, t};
    endfunction

    function automatic logic [TW+4:0] obs_vec();
        return {bus.o_trigger, bus.o_busy, bus.o_stall, bus.o_err, bus.o_clk};
    endfunction

    task automatic step(input bit s, input bit p, input bit c, input bit e);
        bus.i_start = s; bus.i_stop = p; bus.i_clr_err = c; bus.i_clk_ena = e;
        @(posedge clk);
        model_step(s, p, c, e);
        #1;
        bus.i_start = 0; bus.i_stop = 0; bus.i_clr_err = 0;
    endtask

    task automatic test_reset();
        bus.i_start = 0; bus.i_stop = 0; bus.i_clr_err = 0; bus.i_clk_ena = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL reset: got %h expected 0", obs_vec());
        end
        rst = 1'b0;
        step(0, 0, 0, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL reset_idle_ena: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_run();
        step(1, 0, 0, 1);
        checks++;
        if (bus.o_trigger !== 1'b1 || bus.o_clk !== 4'd0 || bus.o_busy !== 1'b1) begin
            errors++; $display("FAIL run_start: got trig %b clk %0d expected 1 0", bus.o_trigger, bus.o_clk);
        end
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 1);
            checks++;
            if (bus.o_clk !== TW'(k) || obs_vec() !== exp_vec()) begin
                errors++; $display("FAIL run_count: got %h expected %h (k=%0d)", obs_vec(), exp_vec(), k);
            end
        end
        step(0, 1, 0, 1);
    endtask

    task automatic test_stall();
        step(1, 0, 0, 1);
        repeat (5) step(0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0);
            checks++;
            if (bus.o_stall !== 1'b1 || bus.o_clk !== 4'd5 || bus.o_trigger !== 1'b1) begin
                errors++; $display("FAIL stall_hold: got stall %b clk %0d expected 1 5", bus.o_stall, bus.o_clk);
            end
        end
        step(0, 0, 0, 1);
        checks++;
        if (bus.o_clk !== 4'd6 || bus.o_stall !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL stall_resume: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_overflow();
        int n = 0;
        while (bus.o_busy === 1'b1 && n < 40) begin step(0, 0, 0, 1); n++; end
        checks++;
        if (bus.o_err !== 2'b01 || bus.o_trigger !== 1'b0 || bus.o_clk !== 4'd15) begin
            errors++; $display("FAIL overflow: got err %b trig %b clk %0d expected 01 0 15", bus.o_err, bus.o_trigger, bus.o_clk);
        end
        step(1, 0, 0, 1);
        step(0, 1, 0, 1);
        checks++;
        if (bus.o_err !== 2'b01 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL err_sticky: got err %b busy %b expected 01 0", bus.o_err, bus.o_busy);
        end
        step(0, 0, 1, 0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.o_err !== 2'b00) begin
            errors++; $display("FAIL clr_err: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_wdog();
        int stall_cycles = 0;
        step(1, 0, 0, 0);
`ifdef QPU_TRIG_WDOG_EN
        while (bus.o_stall !== 1'b0 || stall_cycles == 0) begin
            step(0, 0, 0, 0);
            if (bus.o_stall === 1'b1) stall_cycles++;
            if (stall_cycles > 3 * WLIMIT) break;
        end
        checks++;
        if (stall_cycles != WLIMIT || bus.o_err !== 2'b10 || bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL wdog_timeout: got %0d stall cycles err %b expected %0d 10", stall_cycles, bus.o_err, WLIMIT);
        end
        step(0, 0, 1, 0);
`else
        repeat (120) begin
            step(0, 0, 0, 0);
            if (bus.o_stall === 1'b1) stall_cycles++;
        end
        checks++;
        if (stall_cycles != 120 || bus.o_err !== 2'b00 || bus.o_trigger !== 1'b1) begin
            errors++; $display("FAIL stall_forever: got %0d stall cycles err %b expected 120 00", stall_cycles, bus.o_err);
        end
        step(0, 1, 0, 0);
`endif
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL wdog_exit: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stop();
        step(1, 0, 0, 1);
        repeat (7) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        checks++;
        if (bus.o_trigger !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_clk !== 4'd7) begin
            errors++; $display("FAIL stop: got trig %b clk %0d expected 0 7", bus.o_trigger, bus.o_clk);
        end
        step(1, 1, 0, 1);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_clk !== 4'd7 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL start_stop_same: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1, 0, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== '0) begin
            errors++; $display("FAIL async_reset: got %h expected 0", obs_vec());
        end
        #1 rst = 1'b0;
        step(1, 0, 0, 1);
        checks++;
        if (bus.o_clk !== 4'd0 || bus.o_trigger !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL restart: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_overflow();
        test_wdog();
        test_stop();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
